// File: rtl/wbc_arbiter_pkg.sv
// wbc_arbiter_pkg
//   Shared definitions for the Wishbone multi-master arbiter slice:
//   FSM state encoding, the "no master granted" constant and a width helper.
package wbc_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } wbc_state_e;

    // Grant vector value meaning "no master owns the slave"; callers cast to NM bits.
    localparam logic [31:0] GRANT_NONE = 32'h0000_0000;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int wbc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wbc_arbiter_rrpick.sv
// wbc_arbiter_rrpick
//   Combinational round-robin picker: returns a one-hot vector selecting the
//   first asserted request at or after the pointer, wrapping modulo NM.
//   Ports:
//     i_req   [NM-1:0]  request vector
//     i_ptr   [PW-1:0]  search start index (0..NM-1)
//     o_grant [NM-1:0]  one-hot pick, all zero when no request
module wbc_arbiter_rrpick #(
    parameter int NM = 4,
    parameter int PW = 2
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NM-1:0] o_grant
);

    // Scan NM positions starting at the pointer; the first hit wins.
    always_comb begin : pick
        int   idx;
        logic found;
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NM; k++) begin
            idx = int'(i_ptr) + k;
            idx = (idx >= NM) ? (idx - NM) : idx;
            o_grant[idx] = o_grant[idx] | (i_req[idx] & ~found);
            found        = found | i_req[idx];
        end
    end

endmodule

// File: rtl/wbc_arbiter.sv
// wbc_arbiter
//   Round-robin arbiter letting NM Wishbone masters share one slave.
//   A grant is registered from IDLE, held while the granted master keeps
//   cyc high, and released with one idle cycle before the next grant.
//   An optional watchdog returns a bus error after TIMEOUT unacknowledged
//   strobe cycles (TIMEOUT = 0 disables it).
//   Ports:
//     i_clk, i_reset                    clock, synchronous active-high reset
//     i_mcyc/i_mstb/i_mwe [NM]          per-master cycle/strobe/write enable
//     i_maddr/i_mdata/i_msel            per-master address/write data/byte sel
//     o_mack/o_merr [NM], o_mdata       per-master ack/error/read data
//     o_scyc/o_sstb/o_swe/o_saddr/o_sdata/o_ssel   slave request side
//     i_sack/i_serr/i_sdata             slave response side
//     o_grant [NM]                      one-hot granted master, 0 when idle
module wbc_arbiter
    import wbc_arbiter_pkg::*;
#(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [NM-1:0]    o_merr,
    output logic [NM*DW-1:0] o_mdata,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic             i_serr,
    input  logic [DW-1:0]    i_sdata,
    output logic [NM-1:0]    o_grant
);

    localparam int PW = wbc_width(NM);
    localparam int CW = wbc_width(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam logic          TO_EN  = (TIMEOUT > 0) ? 1'b1 : 1'b0;

    wbc_state_e    state_r;
    logic [NM-1:0] grant_r;
    logic [PW-1:0] gidx_r;
    logic [PW-1:0] rr_ptr_r;
    logic [CW-1:0] cnt_r;

    logic [NM-1:0] pick_s;
    logic [PW-1:0] pick_idx_s;
    logic [PW-1:0] next_ptr_s;
    logic          granted_s;
    logic          gcyc_s;
    logic          gstb_s;
    logic          gwe_s;
    logic [AW-1:0] gaddr_s;
    logic [DW-1:0] gdata_s;
    logic [SW-1:0] gsel_s;
    logic          stall_s;
    logic          timeout_s;

    wbc_arbiter_rrpick #(
        .NM (NM),
        .PW (PW)
    ) u_rrpick (
        .i_req   (i_mcyc),
        .i_ptr   (rr_ptr_r),
        .o_grant (pick_s)
    );

    // Encode the one-hot pick into an index (pick is one-hot or zero).
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NM; i++) begin
            pick_idx_s = pick_idx_s | (pick_s[i] ? PW'(i) : '0);
        end
    end

    // Select the granted master's request and derive the watchdog condition.
    always_comb begin
        granted_s  = (state_r == ST_GRANTED);
        gcyc_s     = i_mcyc[gidx_r];
        gstb_s     = i_mstb[gidx_r];
        gwe_s      = i_mwe[gidx_r];
        gaddr_s    = i_maddr[gidx_r*AW +: AW];
        gdata_s    = i_mdata[gidx_r*DW +: DW];
        gsel_s     = i_msel[gidx_r*SW +: SW];
        next_ptr_s = (gidx_r == PW'(NM - 1)) ? '0 : (gidx_r + PW'(1));
        // A strobe the slave neither acked nor errored this cycle.
        stall_s    = granted_s & gstb_s & ~i_sack & ~i_serr;
        // An ack (or slave error) in the same cycle wins over the watchdog.
        timeout_s  = TO_EN & stall_s & (cnt_r == TO_VAL);
    end

    // Slave-side request: straight copy of the granted master, strobe
    // withheld on the watchdog cycle so the slave sees the access abandoned.
    always_comb begin
        if (granted_s) begin
            o_scyc  = gcyc_s;
            o_sstb  = gstb_s & ~timeout_s;
            o_swe   = gwe_s;
            o_saddr = gaddr_s;
            o_sdata = gdata_s;
            o_ssel  = gsel_s;
        end else begin
            o_scyc  = 1'b0;
            o_sstb  = 1'b0;
            o_swe   = 1'b0;
            o_saddr = '0;
            o_sdata = '0;
            o_ssel  = '0;
        end
    end

    // Master-side response: only the granted master sees ack/err/data; a
    // reset cycle suppresses responses so a dropped grant never completes.
    always_comb begin
        o_mack  = '0;
        o_merr  = '0;
        o_mdata = '0;
        if (granted_s && !i_reset) begin
            o_mack = grant_r & {NM{i_sack}};
            o_merr = grant_r & {NM{i_serr | timeout_s}};
            for (int i = 0; i < NM; i++) begin
                o_mdata[i*DW +: DW] = grant_r[i] ? i_sdata : '0;
            end
        end else begin
            o_mack  = '0;
            o_merr  = '0;
            o_mdata = '0;
        end
    end

    assign o_grant = grant_r;

    // Arbitration FSM, round-robin pointer and saturating watchdog counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= NM'(GRANT_NONE);
            gidx_r   <= '0;
            rr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (|i_mcyc) begin
                        state_r <= ST_GRANTED;
                        grant_r <= pick_s;
                        gidx_r  <= pick_idx_s;
                    end else begin
                        grant_r <= NM'(GRANT_NONE);
                    end
                end
                ST_GRANTED: begin
                    if (!gcyc_s) begin
                        // Release: the following cycle is the mandatory idle gap.
                        state_r  <= ST_IDLE;
                        grant_r  <= NM'(GRANT_NONE);
                        rr_ptr_r <= next_ptr_s;
                        cnt_r    <= '0;
                    end else if (timeout_s) begin
                        cnt_r <= '0;
                    end else if (stall_s) begin
                        cnt_r <= (cnt_r == TO_VAL) ? cnt_r : (cnt_r + CW'(1));
                    end else begin
                        cnt_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= NM'(GRANT_NONE);
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbc_arbiter.sv
module tb_wbc_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0] i_maddr;
    logic [NM*DW-1:0] i_mdata;
    logic [NM*SW-1:0] i_msel;
    logic [NM-1:0]    o_mack, o_merr;
    logic [NM*DW-1:0] o_mdata;
    logic             o_scyc, o_sstb, o_swe;
    logic [AW-1:0]    o_saddr;
    logic [DW-1:0]    o_sdata;
    logic [SW-1:0]    o_ssel;
    logic             i_sack, i_serr;
    logic [DW-1:0]    i_sdata;
    logic [NM-1:0]    o_grant;

    int n_vec = 0;
    int n_err = 0;

    wbc_arbiter #(
        .NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(8)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
        .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
        .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
        .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata),
        .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic nstep();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_mcyc  = '0; i_mstb = '0; i_mwe = '0;
        i_maddr = '0; i_mdata = '0; i_msel = '0;
        i_sack  = 1'b0; i_serr = 1'b0; i_sdata = '0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        i_mcyc[m] = cyc; i_mstb[m] = stb; i_mwe[m] = we;
        i_maddr[m*AW +: AW] = addr;
        i_mdata[m*DW +: DW] = data;
        i_msel[m*SW +: SW]  = sel;
    endtask

    task automatic do_reset();
        nstep(); clear_inputs(); i_reset = 1'b1;
        nstep(); nstep(); i_reset = 1'b0;
    endtask

    task automatic test_reset();
        nstep(); clear_inputs(); i_reset = 1'b1;
        i_mcyc = 4'b1111; i_mstb = 4'b1111;
        nstep(); nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b exp 0000", o_grant); end
        n_vec++;
        if (o_scyc !== 1'b0 || o_sstb !== 1'b0) begin n_err++; $display("FAIL reset_slave got cyc=%b stb=%b exp 0 0", o_scyc, o_sstb); end
        n_vec++;
        if (o_mack !== 4'b0000 || o_merr !== 4'b0000) begin n_err++; $display("FAIL reset_master got ack=%b err=%b exp 0000 0000", o_mack, o_merr); end
        clear_inputs(); i_reset = 1'b0;
    endtask

    // Only M2 requests a read; slave acks on the third granted cycle.
    task automatic test_single_read();
        do_reset();
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        #1;
        n_vec++;
        if (o_grant !== 4'b0000 || o_scyc !== 1'b0) begin n_err++; $display("FAIL read_idle got grant=%b scyc=%b exp 0000 0", o_grant, o_scyc); end
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0100) begin n_err++; $display("FAIL read_grant got %b exp 0100", o_grant); end
        n_vec++;
        if (o_scyc !== 1'b1 || o_sstb !== 1'b1 || o_swe !== 1'b0 || o_saddr !== 32'h0000_0100)
            begin n_err++; $display("FAIL read_slave got cyc=%b stb=%b we=%b addr=%h exp 1 1 0 00000100", o_scyc, o_sstb, o_swe, o_saddr); end
        nstep(); #1;
        n_vec++;
        if (o_mack !== 4'b0000) begin n_err++; $display("FAIL read_noack got %b exp 0000", o_mack); end
        nstep(); i_sack = 1'b1; i_sdata = 32'hDEAD_BEEF; #1;
        n_vec++;
        if (o_mack !== 4'b0100) begin n_err++; $display("FAIL read_ack got %b exp 0100", o_mack); end
        n_vec++;
        if (o_mdata[2*DW +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_data got %h exp deadbeef", o_mdata[2*DW +: DW]); end
        n_vec++;
        if (o_mdata[0 +: DW] !== 32'h0 || o_mdata[3*DW +: DW] !== 32'h0)
            begin n_err++; $display("FAIL read_data_other got m0=%h m3=%h exp 0 0", o_mdata[0 +: DW], o_mdata[3*DW +: DW]); end
        nstep(); clear_inputs(); #1;
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0000 || o_scyc !== 1'b0) begin n_err++; $display("FAIL read_release got grant=%b scyc=%b exp 0000 0", o_grant, o_scyc); end
    endtask

    // All masters request from reset, each does two acked strobes then drops cyc.
    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic       sack;
        int         g, p;
        do_reset();
        for (int k = 0; k <= 17; k++) begin
            if (k == 0 || (k % 4) == 0 || k > 16) exp_g = 4'b0000;
            else begin
                exp_g = 4'b0001 << ((k - 1) / 4);
            end
            g    = (k - 1) / 4;
            p    = (k - 1) % 4;
            sack = (k >= 1) && (k <= 16) && (exp_g != 4'b0000) && (p < 2);
            for (int m = 0; m < NM; m++) begin
                if (k >= 4*m + 3) set_m(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                else set_m(m, 1'b1, 1'b1, 1'b0, 32'h1000 + m, 32'h0, 4'hF);
            end
            i_sack = sack;
            #1;
            n_vec++;
            if (o_grant !== exp_g) begin n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, o_grant, exp_g); end
            n_vec++;
            if (o_mack !== (sack ? exp_g : 4'b0000)) begin n_err++; $display("FAIL rr_ack k=%0d got %b exp %b", k, o_mack, sack ? exp_g : 4'b0000); end
            nstep();
        end
        clear_inputs();
    endtask

    // Slave never acks: one error pulse, 8 strobe cycles after strobe rises.
    task automatic test_timeout();
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
        for (int k = 1; k <= 10; k++) begin
            nstep(); #1;
            n_vec++;
            if (o_merr !== ((k == 9) ? 4'b0010 : 4'b0000))
                begin n_err++; $display("FAIL to_err k=%0d got %b exp %b", k, o_merr, (k == 9) ? 4'b0010 : 4'b0000); end
            n_vec++;
            if (o_sstb !== ((k == 9) ? 1'b0 : 1'b1))
                begin n_err++; $display("FAIL to_stb k=%0d got %b exp %b", k, o_sstb, (k == 9) ? 1'b0 : 1'b1); end
        end
        nstep(); clear_inputs(); nstep();
    endtask

    // Ack lands on the same cycle the counter reaches TIMEOUT.
    task automatic test_ack_at_timeout();
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h3000, 32'hCAFE_0000, 4'h3);
        for (int k = 1; k <= 8; k++) nstep();
        nstep(); i_sack = 1'b1; #1;
        n_vec++;
        if (o_mack !== 4'b0001 || o_merr !== 4'b0000)
            begin n_err++; $display("FAIL ack_to got ack=%b err=%b exp 0001 0000", o_mack, o_merr); end
        n_vec++;
        if (o_sstb !== 1'b1) begin n_err++; $display("FAIL ack_to_stb got %b exp 1", o_sstb); end
        nstep(); i_sack = 1'b0; #1;
        n_vec++;
        if (o_merr !== 4'b0000) begin n_err++; $display("FAIL ack_to_after got %b exp 0000", o_merr); end
        clear_inputs(); nstep();
    endtask

    // Reset while M1 is granted mid-strobe; next grant must go to M0.
    task automatic test_reset_mid();
        do_reset();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF);
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0010) begin n_err++; $display("FAIL rst_mid_grant got %b exp 0010", o_grant); end
        nstep();
        i_reset = 1'b1; i_sack = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h5000, 32'h0, 4'hF);
        #1;
        n_vec++;
        if (o_mack !== 4'b0000) begin n_err++; $display("FAIL rst_mid_noack got %b exp 0000", o_mack); end
        nstep(); i_reset = 1'b0; #1;
        n_vec++;
        if (o_scyc !== 1'b0 || o_grant !== 4'b0000 || o_mack !== 4'b0000)
            begin n_err++; $display("FAIL rst_mid_drop got scyc=%b grant=%b ack=%b exp 0 0000 0000", o_scyc, o_grant, o_mack); end
        nstep(); i_sack = 1'b0; #1;
        n_vec++;
        if (o_grant !== 4'b0001) begin n_err++; $display("FAIL rst_mid_next got %b exp 0001", o_grant); end
        clear_inputs(); nstep(); nstep();
    endtask

    // M3 holds the bus with a write; M0 waits until M3 drops cyc.
    task automatic test_no_preempt();
        do_reset();
        set_m(3, 1'b1, 1'b1, 1'b1, 32'h6000, 32'h1234_5678, 4'hA);
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b1000) begin n_err++; $display("FAIL np_grant got %b exp 1000", o_grant); end
        n_vec++;
        if (o_swe !== 1'b1 || o_sdata !== 32'h1234_5678 || o_ssel !== 4'hA)
            begin n_err++; $display("FAIL np_write got we=%b data=%h sel=%h exp 1 12345678 a", o_swe, o_sdata, o_ssel); end
        nstep();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h7000, 32'h0, 4'hF);
        i_sack = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_vec++;
            if (o_grant !== 4'b1000) begin n_err++; $display("FAIL np_hold k=%0d got %b exp 1000", k, o_grant); end
            nstep();
        end
        set_m(3, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        i_sack = 1'b0;
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0000) begin n_err++; $display("FAIL np_gap got %b exp 0000", o_grant); end
        nstep(); #1;
        n_vec++;
        if (o_grant !== 4'b0001 || o_saddr !== 32'h7000)
            begin n_err++; $display("FAIL np_next got grant=%b addr=%h exp 0001 00007000", o_grant, o_saddr); end
        clear_inputs(); nstep();
    endtask

    initial begin
        clear_inputs();
        i_reset = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_no_preempt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wbc_arbiter.md
WBC_ARBITER -- requirements
Module: wbcarbiter

Interface
REQ-001 SHALL have parameter NM, default 4, number of Wishbone masters sharing one slave.
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have parameter SW, default DW/8, byte-select width.
REQ-005 SHALL have parameter TIMEOUT, default 255, cycles of unacknowledged strobe before bus error; 0 disables.
REQ-006 SHALL have ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mcyc / i_mstb / i_mwe  in  NM  per-master cycle, strobe and write-enable.
- i_maddr  in  NM*AW  per-master address.
- i_mdata  in  NM*DW  per-master write data.
- i_msel  in  NM*SW  per-master byte select.
- o_mack / o_merr  out  NM  per-master ack / error.
- o_mdata  out  NM*DW  per-master read data.
- o_scyc / o_sstb / o_swe  out  1  slave cycle, strobe, write-enable.
- o_saddr  out  AW  slave address.
- o_sdata  out  DW  slave write data.
- o_ssel  out  SW  slave byte select.
- i_sack / i_serr  in  1  slave ack / error.
- i_sdata  in  DW  slave read data.
- o_grant  out  NM  one-hot granted master; 0 when idle.

Function
REQ-007 SHALL implement FSM IDLE/GRANTED.
REQ-008 In IDLE, if any i_mcyc is set, SHALL register a grant to the first requester at or after rr_ptr (modulo NM), and enter GRANTED on the next edge.
REQ-009 In IDLE, o_scyc and o_sstb SHALL be 0, o_grant SHALL be 0, and all o_mack/o_merr SHALL be 0.
REQ-010 In GRANTED, slave outputs SHALL be a combinational copy of the granted master's cyc/stb/we/addr/data/sel (zero extra latency).
REQ-011 In GRANTED, i_sack, i_serr and i_sdata SHALL route only to the granted master; non-granted masters SHALL see ack=0, err=0, data=0.
REQ-012 When the granted master's i_mcyc is 0 in GRANTED, the FSM SHALL go to IDLE on that edge, set rr_ptr = granted+1 mod NM, and leave one idle cycle before the next grant.
REQ-013 A grant SHALL persist across multiple strobes while i_mcyc stays high; no preemption.
REQ-014 The timeout counter SHALL increment each GRANTED cycle with o_sstb=1 and i_sack=0 and i_serr=0, and clear otherwise.
REQ-015 When the counter equals TIMEOUT (TIMEOUT>0), the arbiter SHALL assert o_merr to the granted master for exactly one cycle, force o_sstb=0 that cycle, and clear the counter.
REQ-016 The counter SHALL be wide enough for TIMEOUT (clog2(TIMEOUT+1)) and SHALL saturate rather than wrap.
REQ-017 A simultaneous i_sack and timeout SHALL yield ack only; the error SHALL be suppressed.
REQ-018 With NM=1, the arbiter SHALL degenerate to pass-through plus timeout, keeping the idle cycle.

Reset
REQ-019 On i_reset, the FSM SHALL go to IDLE, rr_ptr=0, counter=0, o_grant=0, and all slave and master outputs 0 from the next edge.
REQ-020 Reset mid-transaction SHALL drop the grant without an ack or err to the master.

Structure
REQ-021 The FSM state encoding and the GRANT_NONE constant SHALL live in a shared wbc header/package.
REQ-022 Round-robin selection SHALL be one combinational sub-module wbcrrpick (request vector, pointer -> one-hot).

Verification
REQ-023 Scenario: NM=4, only M2 requests; read, slave acks at cycle 3 with 0xDEADBEEF -> o_grant=4'b0100, o_mdata[2]=0xDEADBEEF with o_mack[2] in the same cycle.
REQ-024 Scenario: all four masters hold cyc for 2 transactions each from reset -> grants in order M0,M1,M2,M3, with one idle cycle between each.
REQ-025 Scenario: TIMEOUT=8, slave never acks -> o_merr of the granted master pulses once, 8 strobe cycles after the strobe rises.
REQ-026 Scenario: i_sack arrives on the same cycle the counter hits TIMEOUT -> o_mack=1 and o_merr=0.
REQ-027 Scenario: i_reset asserted while M1 is granted mid-strobe -> next cycle o_scyc=0, o_grant=0, no ack to M1, and the next grant goes to M0.
REQ-028 Scenario: M3 granted while M0 requests -> M3 is not preempted, and M0 is granted only after M3 drops cyc.
